// File: rtl/gate_counter.sv
// ---------------------------------------------------------------------------
// gate_counter
//
// Gated frequency counter for an auto-ranging meter. Rising edges of sig_in
// are counted in 4-digit BCD over a gate window whose length (in clk cycles)
// is chosen by the range input. At the end of each gate the result is latched
// and reported, and a new gate starts immediately. Measurement keeps running
// until reset; it only starts after the first clr.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   sig_in    measured signal, asynchronous to clk
//   clr       one-cycle start/clear request; aborts any gate in progress
//   range     range select: 00=100k, 01=10k, 10=1k, 11 behaves as 01
//   cnt_over  one-cycle pulse with valid: gate count exceeded 9999
//   cnt_low   one-cycle pulse with valid: gate count below 1000
//   bcd       latched 4-digit BCD result, [15:12] most significant digit
//   range_q   range in force for the latched bcd value
//   valid     one-cycle pulse: bcd and range_q updated
// ---------------------------------------------------------------------------
module gate_counter #(
   parameter int GATE_100K = 5000,
   parameter int GATE_10K  = 50000,
   parameter int GATE_1K   = 500000,
   parameter int TW        = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sig_in,
   input  logic        clr,
   input  logic [1:0]  range,
   output logic        cnt_over,
   output logic        cnt_low,
   output logic [15:0] bcd,
   output logic [1:0]  range_q,
   output logic        valid
);

   typedef enum logic [1:0] {S_IDLE, S_GATE, S_EVAL} state_t;

   localparam logic [TW-1:0] L_LAST_100K = TW'(GATE_100K - 1);
   localparam logic [TW-1:0] L_LAST_10K  = TW'(GATE_10K - 1);
   localparam logic [TW-1:0] L_LAST_1K   = TW'(GATE_1K - 1);

   // Increment a 4-digit BCD value, rippling the carry through digits at 9.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   state_t        r_state;
   state_t        w_next;
   logic          r_sync1, r_sync2, r_sync_prev;
   logic          w_rise;
   logic [1:0]    r_range;
   logic [1:0]    w_range_norm;
   logic [TW-1:0] r_timer;
   logic [15:0]   r_acc;
   logic          r_ovf;
   logic          w_gate_last;
   logic          w_start;
   logic          w_eval;

   // Range 11 is folded onto 01 so everything downstream sees three ranges.
   assign w_range_norm = (range == 2'b11) ? 2'b01 : range;

   assign w_rise = r_sync2 & ~r_sync_prev;

   always_comb begin
      case (r_range)
         2'b00:   w_gate_last = (r_timer == L_LAST_100K);
         2'b10:   w_gate_last = (r_timer == L_LAST_1K);
         default: w_gate_last = (r_timer == L_LAST_10K);
      endcase
   end

   // ---------------- FSM: state register ----------------
   // NOTE: every clocked process uses non-blocking assignments so all flops
   // sample the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // ---------------- FSM: next-state logic ----------------
   // NOTE: the default assignment at the top keeps this block free of
   // inferred latches on paths that do not assign w_next.
   always_comb begin
      w_next = r_state;
      if (clr) begin
         w_next = S_GATE;
      end else begin
         case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_GATE:  if (w_gate_last) w_next = S_EVAL;
            S_EVAL:  w_next = S_GATE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // ---------------- FSM: output decode ----------------
   // A gate (re)starts on clr from any state or on the automatic EVAL->GATE
   // step. A clr during EVAL suppresses the report of that gate.
   always_comb begin
      w_start = clr || (r_state == S_EVAL);
      w_eval  = (r_state == S_EVAL) && !clr;
   end

   // Two-flop synchronizer plus the previous synchronized level for edges.
   // NOTE: all state, including the BCD accumulator and output latches, is
   // plain flops with an explicit reset value; nothing here is a RAM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_sync_prev <= 1'b0;
      end else begin
         r_sync1     <= sig_in;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
      end
   end

   // Gate timer, range latch and BCD accumulator.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_range <= 2'b00;
         r_timer <= '0;
         r_acc   <= 16'h0000;
         r_ovf   <= 1'b0;
      end else if (w_start) begin
         r_range <= w_range_norm;
         r_timer <= '0;
         r_acc   <= 16'h0000;
         r_ovf   <= 1'b0;
      end else if (r_state == S_GATE) begin
         r_timer <= r_timer + TW'(1);
         if (w_rise) begin
            // Saturate at 9999 and remember that the gate overflowed.
            if (r_acc == 16'h9999) r_ovf <= 1'b1;
            else                   r_acc <= bcd_inc(r_acc);
         end
      end
   end

   // Registered results; bcd and range_q hold between reports, even over clr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bcd      <= 16'h0000;
         range_q  <= 2'b00;
         valid    <= 1'b0;
         cnt_over <= 1'b0;
         cnt_low  <= 1'b0;
      end else begin
         valid    <= w_eval;
         cnt_over <= w_eval && r_ovf;
         cnt_low  <= w_eval && !r_ovf && (r_acc[15:12] == 4'd0);
         if (w_eval) begin
            bcd     <= r_acc;
            range_q <= r_range;
         end
      end
   end

endmodule

// File: tb/tb_gate_counter.sv
// ---------------------------------------------------------------------------
// tb_gate_counter
//
// Drives gate_counter with directed and random sig_in / clr / range traffic.
// A reference model keeps the full history of sig_in levels and, from the
// schedule of gate starts, counts rising edges inside each gate window with
// plain arithmetic. Each predicted report is queued with the cycle it must
// appear in; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_gate_counter;

   localparam int G100 = 10;
   localparam int G10  = 2468;
   localparam int G1   = 20010;
   // sig_in sampled in cycle k is seen as an edge by the counter in cycle k+2.
   localparam int SYNC_LAT = 2;

   typedef struct {
      int          due;
      logic [15:0] bcd;
      logic [1:0]  rng;
      logic        over;
      logic        low;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        sig_in;
   logic        clr;
   logic [1:0]  range;
   logic        cnt_over, cnt_low, valid;
   logic [15:0] bcd;
   logic [1:0]  range_q;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   period;
   int   n_push = 0;
   int   n_pop  = 0;
   bit   s_hist [0:65535];
   exp_t sb [$];

   // Model of the gate schedule.
   bit   m_active = 1'b0;
   int   m_start;
   int   m_len;
   logic [1:0] m_rng;

   gate_counter #(
      .GATE_100K(G100),
      .GATE_10K (G10),
      .GATE_1K  (G1),
      .TW       (20)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sig_in  (sig_in),
      .clr     (clr),
      .range   (range),
      .cnt_over(cnt_over),
      .cnt_low (cnt_low),
      .bcd     (bcd),
      .range_q (range_q),
      .valid   (valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish (cycle=%0d)", cyc);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, wanted %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [1:0] norm(input logic [1:0] r);
      return (r == 2'b11) ? 2'b01 : r;
   endfunction

   function automatic int gate_len(input logic [1:0] r);
      case (norm(r))
         2'b00:   return G100;
         2'b10:   return G1;
         default: return G10;
      endcase
   endfunction

   function automatic logic [15:0] to_bcd(input int n);
      int v;
      v = (n > 9999) ? 9999 : n;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Count rising edges of sig_in that land in the gate opened at cycle g.
   task automatic close_gate(input int k);
      exp_t e;
      int   n;
      n = 0;
      for (int j = m_start + 1 - SYNC_LAT; j <= m_start + m_len - SYNC_LAT; j++)
         if (j >= 1 && s_hist[j] && !s_hist[j-1]) n++;
      e.due  = k + 1;
      e.bcd  = to_bcd(n);
      e.rng  = m_rng;
      e.over = (n > 9999);
      e.low  = (n <= 9999) && (n < 1000);
      sb.push_back(e);
      n_push++;
   endtask

   // Called once per cycle with the inputs that were present during cycle k.
   task automatic predict(input int k, input logic c, input logic [1:0] r);
      if (!reset) begin
         m_active = 1'b0;
      end else if (c) begin
         m_active = 1'b1;
         m_start  = k;
         m_len    = gate_len(r);
         m_rng    = norm(r);
      end else if (m_active && k == m_start + m_len + 1) begin
         close_gate(k);
         m_start = k;
         m_len   = gate_len(r);
         m_rng   = norm(r);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      s_hist[cyc] = sig_in;
      predict(cyc, clr, range);
      cyc++;
      #1;
      if (period == 0) sig_in = 1'($urandom_range(1, 0));
      else             sig_in = ((cyc % period) < (period / 2));
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_clr(input logic [1:0] r);
      range = r;
      clr   = 1'b1;
      tick();
      clr   = 1'b0;
   endtask

   // Monitor: every report must match the head of the scoreboard, on time.
   always @(negedge clk) begin
      if (reset) begin
         while (sb.size() > 0 && sb[0].due < cyc) begin
            check("missing_valid_due", 32'(cyc), 32'(sb[0].due));
            void'(sb.pop_front());
         end
         if (valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'(valid), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               n_pop++;
               check("valid_cycle", 32'(cyc), 32'(e.due));
               check("bcd", 32'(bcd), 32'(e.bcd));
               check("range_q", 32'(range_q), 32'(e.rng));
               check("cnt_over", 32'(cnt_over), 32'(e.over));
               check("cnt_low", 32'(cnt_low), 32'(e.low));
            end
         end else if (cnt_over || cnt_low) begin
            check("flag_without_valid", 32'({cnt_over, cnt_low}), 32'd0);
         end
      end
   end

   initial begin
      reset  = 1'b0;
      clr    = 1'b0;
      range  = 2'b00;
      sig_in = 1'b0;
      period = 2;

      // Reset state.
      run(3);
      check("rst_bcd", 32'(bcd), 32'h0000);
      check("rst_range_q", 32'(range_q), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_over", 32'(cnt_over), 32'd0);
      check("rst_low", 32'(cnt_low), 32'd0);
      reset = 1'b1;

      // No measurement before the first clr (monitor flags any valid).
      run(20);

      // Short gates, sig_in toggling every clk, then random sig_in.
      pulse_clr(2'b00);
      run(5 * (G100 + 1) + 3);
      period = 0;
      run(5 * (G100 + 1));

      // Range 11 behaves as 01; period-4 signal.
      period = 4;
      pulse_clr(2'b11);
      run(G10 + 2);

      // Abort a gate 100 cycles in; range change mid-gate must be ignored.
      period = 2;
      run(100);
      pulse_clr(2'b01);
      run(50);
      range = 2'b00;
      run(G10 + 1 - 50);
      check("abort_valid_at_N_plus_2", 32'(valid), 32'd1);
      check("abort_bcd_1234", 32'(bcd), 32'h1234);
      check("abort_range_q", 32'(range_q), 32'd1);

      // Asynchronous reset mid-gate while bcd holds 1234.
      run(4);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_bcd", 32'(bcd), 32'h0000);
      check("midrst_range_q", 32'(range_q), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_over", 32'(cnt_over), 32'd0);
      check("midrst_low", 32'(cnt_low), 32'd0);
      n_push -= sb.size();
      sb.delete();
      run(3);
      reset = 1'b1;
      run(30);

      // Overflow on the long range, then a slow signal in the next gate.
      pulse_clr(2'b10);
      run(G1 + 1);
      check("ovf_valid", 32'(valid), 32'd1);
      check("ovf_bcd", 32'(bcd), 32'h9999);
      check("ovf_over", 32'(cnt_over), 32'd1);
      check("ovf_low", 32'(cnt_low), 32'd0);
      period = 40;
      run(G1 + 1);

      // Random traffic: random sig_in, sporadic clr and range changes.
      period = 0;
      pulse_clr(2'b00);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(39, 0) == 0) begin
            pulse_clr($urandom_range(1, 0) != 0 ? 2'b11 : 2'b00);
         end else begin
            if ($urandom_range(49, 0) == 0)
               range = ($urandom_range(1, 0) != 0) ? 2'b11 : 2'b00;
            tick();
         end
      end

      // Drain: every predicted report must have appeared.
      run(G10 + 150);
      @(negedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      check("reports_seen", 32'(n_pop), 32'(n_push));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gate_counter.md
GATE_COUNTER -- requirements
Module: gate_counter

Interface
REQ-001 SHALL provide parameter GATE_100K, default 5000, clock cycles per gate for range 2'b00.
REQ-002 SHALL provide parameter GATE_10K, default 50000, clock cycles per gate for range 2'b01.
REQ-003 SHALL provide parameter GATE_1K, default 500000, clock cycles per gate for range 2'b10.
REQ-004 SHALL provide parameter TW, default 20, gate-timer width in bits. Every GATE_* value SHALL fit in TW bits.
REQ-005 clk  input  1  system clock; the only clock; all flops on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 sig_in  input  1  measured signal; asynchronous to clk.
REQ-008 clr  input  1  one-cycle start/clear request from the range controller.
REQ-009 range  input  2  range select from the range controller: 00=100k, 01=10k, 10=1k, 11=treated as 01.
REQ-010 cnt_over  output  1  one-cycle pulse: the gate result exceeded 9999.
REQ-011 cnt_low  output  1  one-cycle pulse: the gate result was below 1000.
REQ-012 bcd  output  16  latched 4-digit BCD result; [15:12] is the most significant digit.
REQ-013 range_q  output  2  range in force for the latched bcd value.
REQ-014 valid  output  1  one-cycle pulse: bcd and range_q updated.

Function
REQ-015 sig_in SHALL pass through a 2-flop synchronizer; a rising edge SHALL be the synchronized level 1 with the previous synchronized level 0.
REQ-016 The FSM SHALL have states IDLE, GATE and EVAL.
REQ-017 IDLE SHALL wait for clr; clr SHALL move the FSM to GATE on the next edge.
REQ-018 Entering GATE SHALL latch range into an internal register, zero the gate timer, zero the BCD accumulator and clear the overflow flag.
REQ-019 In GATE, the timer SHALL increment each cycle. When the timer equals GATE_sel-1, the FSM SHALL go to EVAL. GATE therefore lasts exactly GATE_sel cycles.
REQ-020 In GATE, each detected rising edge SHALL increment the accumulator as a 4-digit BCD value, with a per-digit carry from 9 to 0. An edge detected in the final GATE cycle SHALL be counted.
REQ-021 On an edge while the accumulator is 9999: the accumulator SHALL saturate at 9999 and a sticky overflow flag SHALL set.
REQ-022 EVAL SHALL last one cycle and SHALL, with registered outputs:
- load bcd from the accumulator;
- load range_q from the latched range;
- pulse valid.
REQ-023 cnt_over and cnt_low SHALL be decided in the same EVAL cycle:
- cnt_over SHALL pulse when the overflow flag is set;
- otherwise cnt_low SHALL pulse when the most significant digit is 0;
- the two SHALL never be asserted together.
REQ-024 Outputs SHALL appear one cycle after EVAL: valid, cnt_over and cnt_low all high in the same cycle.
REQ-025 From EVAL the FSM SHALL re-enter GATE automatically (continuous measurement), applying REQ-018 with the current range.
REQ-026 clr SHALL take priority in any state. clr in GATE or EVAL SHALL abort the gate with no valid, cnt_over or cnt_low pulse. It SHALL re-enter GATE on the next edge per REQ-018.
REQ-027 A range change without clr SHALL NOT affect a gate in progress; it SHALL take effect at the next gate start.
REQ-028 bcd and range_q SHALL hold their value between valid pulses, including across clr.

Reset
REQ-029 reset low SHALL asynchronously force the following, and SHALL abort any gate mid-operation:
- FSM to IDLE;
- synchronizer flops, timer, accumulator and overflow flag to 0;
- bcd=16'h0000, range_q=2'b00;
- valid=0, cnt_over=0, cnt_low=0.
REQ-030 After reset release, counting SHALL NOT start until the first clr.

Verification
REQ-031 GATE_10K=20000; range=01; clr pulse; sig_in period 4 clk -> valid at gate end, bcd=16'h5000, range_q=01, cnt_over=0, cnt_low=0.
REQ-032 Same setup, sig_in period 2 clk (10000 edges) -> bcd=16'h9999, cnt_over=1 for one cycle, cnt_low=0.
REQ-033 Same setup, sig_in period 40 clk (500 edges) -> bcd=16'h0500, cnt_low=1 for one cycle, cnt_over=0.
REQ-034 Second clr 100 cycles into a gate -> no valid pulse for the aborted gate; next valid arrives exactly GATE_10K+2 cycles after that clr; range changed mid-gate is ignored until the next gate.
REQ-035 reset low mid-gate while bcd=16'h1234 -> all outputs 0 immediately; no counting after release until clr.
REQ-036 GATE_100K=10; range=00; sig_in toggling every clk; edge in final gate cycle -> that edge is included in bcd; back-to-back valid pulses every 11 cycles.
